// File: rtl/ls_stream_sel_sequencer.sv
// Load/store stream-select sequencer.
// Snapshots per-slot crossbar select configurations on start and presents them
// one slot at a time. It advances on each step handshake and loops over the
// slot list for the requested number of iterations.
// Optional: define MAGE_LS_SEL_PERF_EN to add the stall_cycles_o counter.
module ls_stream_sel_sequencer #(
  parameter int unsigned N_SLOTS  = 4,
  parameter int unsigned N_GROUPS = 4,
  parameter int unsigned N_BANKS  = 2,
  parameter int unsigned L_SEL_W  = 2,
  parameter int unsigned S_SEL_W  = 2,
  parameter int unsigned ITER_W   = 16
) (
  input  logic                                            clk_i,
  input  logic                                            rst_n_i,
  input  logic                                            start_i,
  input  logic                                            abort_i,
  input  logic [$clog2(N_SLOTS+1)-1:0]                    n_slots_i,
  input  logic [ITER_W-1:0]                               n_iter_i,
  input  logic [N_SLOTS*N_GROUPS*N_BANKS*L_SEL_W-1:0]     l_sel_cfg_i,
  input  logic [N_SLOTS*N_GROUPS*N_BANKS*S_SEL_W-1:0]     s_sel_cfg_i,
  input  logic                                            step_i,
  output logic [N_GROUPS-1:0][N_BANKS-1:0][L_SEL_W-1:0]   l_stream_sel_o,
  output logic [N_GROUPS-1:0][N_BANKS-1:0][S_SEL_W-1:0]   s_stream_sel_o,
  output logic                                            sel_valid_o,
  output logic [$clog2(N_SLOTS)-1:0]                      slot_idx_o,
  output logic [ITER_W-1:0]                               iter_idx_o,
  output logic                                            busy_o,
  output logic                                            done_o
`ifdef MAGE_LS_SEL_PERF_EN
  ,
  output logic [31:0]                                     stall_cycles_o
`endif
);

  localparam int unsigned CNT_W  = $clog2(N_SLOTS+1);
  localparam int unsigned SLOT_W = $clog2(N_SLOTS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Packed views: element [s][g][b] sits at bit ((s*N_GROUPS+g)*N_BANKS+b)*W.
  typedef logic [N_SLOTS-1:0][N_GROUPS-1:0][N_BANKS-1:0][L_SEL_W-1:0] l_cfg_t;
  typedef logic [N_SLOTS-1:0][N_GROUPS-1:0][N_BANKS-1:0][S_SEL_W-1:0] s_cfg_t;

  state_t              state_q;
  l_cfg_t              l_cfg_in;
  s_cfg_t              s_cfg_in;
  l_cfg_t              l_cfg_q;
  s_cfg_t              s_cfg_q;
  logic [CNT_W-1:0]    n_slots_q;
  logic [ITER_W-1:0]   n_iter_q;
  logic [CNT_W-1:0]    n_slots_eff;
  logic [SLOT_W-1:0]   slot_nxt;
  logic                last_slot;
  logic                last_iter;
  logic                zero_len;

  // Reinterpret the flat config ports and derive the step decisions.
  assign l_cfg_in    = l_sel_cfg_i;
  assign s_cfg_in    = s_sel_cfg_i;
  assign n_slots_eff = (n_slots_i > CNT_W'(N_SLOTS)) ? CNT_W'(N_SLOTS) : n_slots_i;
  assign slot_nxt    = slot_idx_o + SLOT_W'(1);
  assign last_slot   = (CNT_W'(slot_idx_o) == (n_slots_q - CNT_W'(1)));
  assign last_iter   = (iter_idx_o == (n_iter_q - ITER_W'(1)));
  assign zero_len    = (n_slots_i == '0) || (n_iter_i == '0);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= IDLE;
      l_cfg_q        <= '0;
      s_cfg_q        <= '0;
      n_slots_q      <= '0;
      n_iter_q       <= '0;
      l_stream_sel_o <= '0;
      s_stream_sel_o <= '0;
      sel_valid_o    <= 1'b0;
      slot_idx_o     <= '0;
      iter_idx_o     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else if (abort_i) begin
      state_q        <= IDLE;
      l_stream_sel_o <= '0;
      s_stream_sel_o <= '0;
      sel_valid_o    <= 1'b0;
      slot_idx_o     <= '0;
      iter_idx_o     <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            busy_o <= 1'b1;
            if (zero_len) begin
              state_q <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_q        <= RUN;
              l_cfg_q        <= l_cfg_in;
              s_cfg_q        <= s_cfg_in;
              n_slots_q      <= n_slots_eff;
              n_iter_q       <= n_iter_i;
              slot_idx_o     <= '0;
              iter_idx_o     <= '0;
              l_stream_sel_o <= l_cfg_in[0];
              s_stream_sel_o <= s_cfg_in[0];
              sel_valid_o    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (step_i && sel_valid_o) begin
            if (!last_slot) begin
              slot_idx_o     <= slot_nxt;
              l_stream_sel_o <= l_cfg_q[slot_nxt];
              s_stream_sel_o <= s_cfg_q[slot_nxt];
            end else if (!last_iter) begin
              slot_idx_o     <= '0;
              iter_idx_o     <= iter_idx_o + ITER_W'(1);
              l_stream_sel_o <= l_cfg_q[0];
              s_stream_sel_o <= s_cfg_q[0];
            end else begin
              state_q     <= DONE;
              sel_valid_o <= 1'b0;
              done_o      <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          busy_o      <= 1'b0;
          sel_valid_o <= 1'b0;
          done_o      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAGE_LS_SEL_PERF_EN
  // Saturating count of RUN cycles without a step; cleared on an accepted start.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cycles_o <= '0;
    end else if ((state_q == IDLE) && start_i && !abort_i) begin
      stall_cycles_o <= '0;
    end else if ((state_q == RUN) && !step_i && (stall_cycles_o != '1)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ls_stream_sel_sequencer.sv
// Directed testbench for ls_stream_sel_sequencer.
module tb_ls_stream_sel_sequencer;

  localparam int unsigned N_SLOTS  = 4;
  localparam int unsigned N_GROUPS = 4;
  localparam int unsigned N_BANKS  = 2;
  localparam int unsigned L_SEL_W  = 2;
  localparam int unsigned S_SEL_W  = 2;
  localparam int unsigned ITER_W   = 16;

  typedef logic [N_GROUPS-1:0][N_BANKS-1:0][L_SEL_W-1:0] l_sel_t;
  typedef logic [N_GROUPS-1:0][N_BANKS-1:0][S_SEL_W-1:0] s_sel_t;
  typedef logic [N_SLOTS*N_GROUPS*N_BANKS*L_SEL_W-1:0]   l_flat_t;
  typedef logic [N_SLOTS*N_GROUPS*N_BANKS*S_SEL_W-1:0]   s_flat_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          start = 1'b0;
  logic                          abort = 1'b0;
  logic [$clog2(N_SLOTS+1)-1:0]  n_slots = '0;
  logic [ITER_W-1:0]             n_iter = '0;
  l_flat_t                       l_cfg = '0;
  s_flat_t                       s_cfg = '0;
  logic                          step = 1'b0;
  l_sel_t                        l_sel;
  s_sel_t                        s_sel;
  logic                          sel_valid;
  logic [$clog2(N_SLOTS)-1:0]    slot_idx;
  logic [ITER_W-1:0]             iter_idx;
  logic                          busy;
  logic                          done;
`ifdef MAGE_LS_SEL_PERF_EN
  logic [31:0]                   stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ls_stream_sel_sequencer #(
    .N_SLOTS(N_SLOTS), .N_GROUPS(N_GROUPS), .N_BANKS(N_BANKS),
    .L_SEL_W(L_SEL_W), .S_SEL_W(S_SEL_W), .ITER_W(ITER_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
    .n_slots_i(n_slots), .n_iter_i(n_iter),
    .l_sel_cfg_i(l_cfg), .s_sel_cfg_i(s_cfg), .step_i(step),
    .l_stream_sel_o(l_sel), .s_stream_sel_o(s_sel),
    .sel_valid_o(sel_valid), .slot_idx_o(slot_idx), .iter_idx_o(iter_idx),
    .busy_o(busy), .done_o(done)
`ifdef MAGE_LS_SEL_PERF_EN
    , .stall_cycles_o(stall_cycles)
`endif
  );

  // Field value patterns, parameterised by a seed so configs can differ.
  function automatic logic [L_SEL_W-1:0] l_fld(int s, int g, int b, int seed);
    return L_SEL_W'((s + g + b + seed) % 4);
  endfunction
  function automatic logic [S_SEL_W-1:0] s_fld(int s, int g, int b, int seed);
    return S_SEL_W'((3*s + 2*g + b + seed) % 4);
  endfunction

  // Flat config built from the bit positions the packing rule gives.
  function automatic l_flat_t build_l(int seed);
    l_flat_t r = '0;
    for (int s = 0; s < int'(N_SLOTS); s++)
      for (int g = 0; g < int'(N_GROUPS); g++)
        for (int b = 0; b < int'(N_BANKS); b++)
          for (int k = 0; k < int'(L_SEL_W); k++)
            r[((s*int'(N_GROUPS)+g)*int'(N_BANKS)+b)*int'(L_SEL_W)+k] = l_fld(s, g, b, seed)[k];
    return r;
  endfunction
  function automatic s_flat_t build_s(int seed);
    s_flat_t r = '0;
    for (int s = 0; s < int'(N_SLOTS); s++)
      for (int g = 0; g < int'(N_GROUPS); g++)
        for (int b = 0; b < int'(N_BANKS); b++)
          for (int k = 0; k < int'(S_SEL_W); k++)
            r[((s*int'(N_GROUPS)+g)*int'(N_BANKS)+b)*int'(S_SEL_W)+k] = s_fld(s, g, b, seed)[k];
    return r;
  endfunction
  function automatic l_sel_t exp_l(int s, int seed);
    l_sel_t r;
    for (int g = 0; g < int'(N_GROUPS); g++)
      for (int b = 0; b < int'(N_BANKS); b++) r[g][b] = l_fld(s, g, b, seed);
    return r;
  endfunction
  function automatic s_sel_t exp_s(int s, int seed);
    s_sel_t r;
    for (int g = 0; g < int'(N_GROUPS); g++)
      for (int b = 0; b < int'(N_BANKS); b++) r[g][b] = s_fld(s, g, b, seed);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h required 0",
                         {l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done});
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: busy=%b valid=%b done=%b required 0 0 0", busy, sel_valid, done);
    end
  endtask

  task automatic test_two_slots();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 2; n_iter = 2;
    pulse_start();
    n_checks++;
    if (sel_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL two_first_run: valid=%b busy=%b required 1 1", sel_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (slot_idx !== 2'(k % 2) || iter_idx !== 16'(k / 2)) begin
        n_fail++; $display("FAIL two_idx[%0d]: slot=%0d iter=%0d required %0d %0d", k, slot_idx, iter_idx, k % 2, k / 2);
      end
      n_checks++;
      if (l_sel[0][0] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL two_l00[%0d]: got %b required %b", k, l_sel[0][0], (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      n_checks++;
      if (l_sel !== exp_l(k % 2, 1) || s_sel !== exp_s(k % 2, 1)) begin
        n_fail++; $display("FAIL two_sel[%0d]: got %h/%h required %h/%h", k, l_sel, s_sel, exp_l(k % 2, 1), exp_s(k % 2, 1));
      end
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL two_early_done[%0d]: got %b required 0", k, done);
      end
      tick(); tick();
      n_checks++;
      if (slot_idx !== 2'(k % 2)) begin
        n_fail++; $display("FAIL two_hold[%0d]: slot=%0d required %0d", k, slot_idx, k % 2);
      end
      step = 1'b1; tick(); step = 1'b0;
    end
    n_checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0 || l_sel[0][0] !== 2'b10) begin
      n_fail++; $display("FAIL two_done: done=%b valid=%b l00=%b required 1 0 10", done, sel_valid, l_sel[0][0]);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL two_after: done=%b busy=%b valid=%b required 0 0 0", done, busy, sel_valid);
    end
  endtask

  task automatic test_step_held();
    int cnt = 0;
    int max_iter = 0;
    bit saw_done = 1'b0;
    l_cfg = build_l(2); s_cfg = build_s(2); n_slots = 4; n_iter = 3;
    pulse_start();
    step = 1'b1;
    for (int c = 0; c < 50 && !saw_done; c++) begin
      if (int'(iter_idx) > max_iter) max_iter = int'(iter_idx);
      tick();
      cnt++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    step = 1'b0;
    n_checks++;
    if (!saw_done || cnt != 12) begin
      n_fail++; $display("FAIL held_latency: done_seen=%0d cycles=%0d required 1 12", saw_done, cnt);
    end
    n_checks++;
    if (max_iter != 2 || sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL held_iter: max_iter=%0d valid=%b required 2 0", max_iter, sel_valid);
    end
    tick();
  endtask

  task automatic test_clamp();
    int cnt = 0;
    int max_slot = 0;
    bit saw_done = 1'b0;
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 7; n_iter = 1;
    pulse_start();
    step = 1'b1;
    for (int c = 0; c < 20 && !saw_done; c++) begin
      if (int'(slot_idx) > max_slot) max_slot = int'(slot_idx);
      tick();
      cnt++;
      if (done === 1'b1) saw_done = 1'b1;
    end
    step = 1'b0;
    n_checks++;
    if (!saw_done || cnt != 4 || max_slot != 3) begin
      n_fail++; $display("FAIL clamp: done_seen=%0d cycles=%0d max_slot=%0d required 1 4 3", saw_done, cnt, max_slot);
    end
    tick();
  endtask

  task automatic test_zero_len();
    n_slots = 2; n_iter = 0;
    pulse_start();
    n_checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL zero_iter: done=%b valid=%b busy=%b required 1 0 1", done, sel_valid, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || sel_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_iter_after: done=%b valid=%b busy=%b required 0 0 0", done, sel_valid, busy);
    end
    n_slots = 0; n_iter = 5;
    pulse_start();
    n_checks++;
    if (done !== 1'b1 || sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_slots: done=%b valid=%b required 1 0", done, sel_valid);
    end
    tick();
  endtask

  task automatic test_single_slot();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 1; n_iter = 3;
    pulse_start();
    step = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (slot_idx !== 2'd0 || iter_idx !== 16'(k) || l_sel !== exp_l(0, 1) || sel_valid !== 1'b1) begin
        n_fail++; $display("FAIL single[%0d]: slot=%0d iter=%0d l=%h valid=%b required 0 %0d %h 1",
                           k, slot_idx, iter_idx, l_sel, sel_valid, k, exp_l(0, 1));
      end
      tick();
    end
    step = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL single_done: got %b required 1", done);
    end
    tick();
  endtask

  task automatic test_abort();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 4; n_iter = 3;
    pulse_start();
    step = 1'b1;
    repeat (6) tick();
    step = 1'b0;
    n_checks++;
    if (slot_idx !== 2'd2 || iter_idx !== 16'd1 || sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_pos: slot=%0d iter=%0d valid=%b required 2 1 1", slot_idx, iter_idx, sel_valid);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++;
    if ({l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done} !== '0) begin
      n_fail++; $display("FAIL abort_clear: got %0h required 0",
                         {l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done});
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_nodone: done=%b busy=%b required 0 0", done, busy);
    end
    l_cfg = build_l(3); s_cfg = build_s(3); n_slots = 2; n_iter = 1;
    pulse_start();
    n_checks++;
    if (slot_idx !== 2'd0 || iter_idx !== 16'd0 || l_sel[0][0] !== 2'b11 ||
        l_sel !== exp_l(0, 3) || s_sel !== exp_s(0, 3)) begin
      n_fail++; $display("FAIL abort_restart: slot=%0d iter=%0d l=%h s=%h required 0 0 %h %h",
                         slot_idx, iter_idx, l_sel, s_sel, exp_l(0, 3), exp_s(0, 3));
    end
    abort = 1'b1; tick(); abort = 1'b0;
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_idle: busy=%b valid=%b required 0 0", busy, sel_valid);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_idle2: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_cfg_change();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 2; n_iter = 1;
    pulse_start();
    l_cfg = '1; s_cfg = '1;
    pulse_start();
    n_checks++;
    if (slot_idx !== 2'd0 || l_sel !== exp_l(0, 1) || sel_valid !== 1'b1) begin
      n_fail++; $display("FAIL cfg_start_ignored: slot=%0d l=%h valid=%b required 0 %h 1", slot_idx, l_sel, sel_valid, exp_l(0, 1));
    end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++;
    if (slot_idx !== 2'd1 || l_sel !== exp_l(1, 1) || s_sel !== exp_s(1, 1)) begin
      n_fail++; $display("FAIL cfg_shadow: slot=%0d l=%h s=%h required 1 %h %h", slot_idx, l_sel, s_sel, exp_l(1, 1), exp_s(1, 1));
    end
    step = 1'b1; tick(); step = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL cfg_done: got %b required 1", done);
    end
    tick();
  endtask

  task automatic test_step_idle();
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL step_idle: busy=%b valid=%b done=%b required 0 0 0", busy, sel_valid, done);
    end
  endtask

`ifdef MAGE_LS_SEL_PERF_EN
  task automatic test_perf();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 1; n_iter = 2;
    pulse_start();
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_clear: got %0d required 0", stall_cycles);
    end
    repeat (5) tick();
    n_checks++;
    if (stall_cycles !== 32'd5) begin
      n_fail++; $display("FAIL perf_count: got %0d required 5", stall_cycles);
    end
    step = 1'b1; tick(); tick(); step = 1'b0;
    tick();
    n_checks++;
    if (stall_cycles !== 32'd5 || busy !== 1'b0) begin
      n_fail++; $display("FAIL perf_hold: got %0d busy=%b required 5 0", stall_cycles, busy);
    end
    pulse_start();
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL perf_restart: got %0d required 0", stall_cycles);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_run();
    l_cfg = build_l(1); s_cfg = build_s(1); n_slots = 4; n_iter = 3;
    pulse_start();
    step = 1'b1; tick(); tick(); step = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done} !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: got %0h required 0",
                         {l_sel, s_sel, sel_valid, slot_idx, iter_idx, busy, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0 || slot_idx !== 2'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_release: busy=%b valid=%b slot=%0d done=%b required 0 0 0 0",
                         busy, sel_valid, slot_idx, done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_slots();
    test_step_held();
    test_clamp();
    test_zero_len();
    test_single_slot();
    test_abort();
    test_cfg_change();
    test_step_idle();
`ifdef MAGE_LS_SEL_PERF_EN
    test_perf();
`endif
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
